// File: rtl/id_operand_stage.sv
// Decode operand stage: regfile read, youngest-first forwarding, load-use stall, ID/EX slot.
// Optional ID_STALL_PERF_EN adds stall/issue performance counters with perf_clr.
module id_operand_stage #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int NUM_FWD   = 2,
  parameter int STALL_MAX = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dec_valid,
  output logic                      dec_ready,
  input  logic                      dec_rs_read,
  input  logic [REG_AW-1:0]         dec_rs,
  input  logic                      dec_rt_read,
  input  logic [REG_AW-1:0]         dec_rt,
  input  logic [DATA_W-1:0]         dec_imm,
  input  logic [7:0]                dec_aluop,
  input  logic [2:0]                dec_alusel,
  input  logic                      dec_wreg,
  input  logic [REG_AW-1:0]         dec_wd,
  output logic [REG_AW-1:0]         rf_raddr1,
  output logic [REG_AW-1:0]         rf_raddr2,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]        fwd_wreg,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wd,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic                      flush,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [DATA_W-1:0]         ex_reg1,
  output logic [DATA_W-1:0]         ex_reg2,
  output logic [7:0]                ex_aluop,
  output logic [2:0]                ex_alusel,
  output logic                      ex_wreg,
  output logic [REG_AW-1:0]         ex_wd,
  output logic                      stall_timeout
`ifdef ID_STALL_PERF_EN
  ,
  input  logic                      perf_clr,
  output logic [31:0]               perf_stall_cnt,
  output logic [31:0]               perf_issue_cnt
`endif
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  // Returns {pending, operand}; lowest index wins, so scan oldest to youngest.
  function automatic logic [DATA_W:0] resolve(
    input logic                      rd,
    input logic [REG_AW-1:0]         a,
    input logic [DATA_W-1:0]         rf,
    input logic [NUM_FWD-1:0]        wr,
    input logic [NUM_FWD-1:0]        pend,
    input logic [NUM_FWD*REG_AW-1:0] wd,
    input logic [NUM_FWD*DATA_W-1:0] wdat
  );
    logic [DATA_W:0] r;
    r = {1'b0, rf};
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (wr[k] && wd[k*REG_AW +: REG_AW] == a)
        r = {pend[k], wdat[k*DATA_W +: DATA_W]};
    end
    if (a == '0) r = '0;
    if (!rd) r = {1'b0, dec_imm};
    return r;
  endfunction

  logic [DATA_W:0]   res1, res2;
  logic              hazard, xfer;
  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d, cnt_base;
  logic              to_q, to_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] reg1_q, reg2_q;
  logic [7:0]        aluop_q;
  logic [2:0]        alusel_q;
  logic              wreg_q;
  logic [REG_AW-1:0] wd_q;

  assign rf_raddr1 = dec_rs;
  assign rf_raddr2 = dec_rt;

  always_comb begin
    res1 = resolve(dec_rs_read, dec_rs, rf_rdata1,
                   fwd_wreg, fwd_pending, fwd_wd, fwd_wdata);
    res2 = resolve(dec_rt_read, dec_rt, rf_rdata2,
                   fwd_wreg, fwd_pending, fwd_wd, fwd_wdata);
  end

  assign hazard    = res1[DATA_W] | res2[DATA_W];
  assign dec_ready = !hazard && !flush && (!valid_q || ex_ready);
  assign xfer      = dec_valid && dec_ready;

  always_comb begin
    valid_d = valid_q;
    if (flush)         valid_d = 1'b0;
    else if (xfer)     valid_d = 1'b1;
    else if (ex_ready) valid_d = 1'b0;
  end

  always_comb begin
    state_d = S_EMPTY;
    if (flush)                     state_d = S_EMPTY;
    else if (dec_valid && hazard)  state_d = S_STALL;
    else if (valid_d)              state_d = S_FULL;
  end

  // Counter runs only through consecutive hazard cycles; backpressure is not counted.
  always_comb begin
    cnt_base = (state_q == S_STALL) ? cnt_q : 8'd0;
    cnt_d    = 8'd0;
    if (state_d == S_STALL)
      cnt_d = (cnt_base == 8'hFF) ? cnt_base : cnt_base + 8'd1;
    to_d = to_q | ((state_d == S_STALL) && (cnt_d >= 8'(STALL_MAX)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_EMPTY;
      cnt_q    <= '0;
      to_q     <= 1'b0;
      valid_q  <= 1'b0;
      reg1_q   <= '0;
      reg2_q   <= '0;
      aluop_q  <= '0;
      alusel_q <= '0;
      wreg_q   <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      valid_q <= valid_d;
      if (xfer) begin
        reg1_q   <= res1[DATA_W-1:0];
        reg2_q   <= res2[DATA_W-1:0];
        aluop_q  <= dec_aluop;
        alusel_q <= dec_alusel;
        wreg_q   <= dec_wreg;
        wd_q     <= dec_wd;
      end
    end
  end

  assign ex_valid      = valid_q;
  assign ex_reg1       = reg1_q;
  assign ex_reg2       = reg2_q;
  assign ex_aluop      = aluop_q;
  assign ex_alusel     = alusel_q;
  assign ex_wreg       = wreg_q;
  assign ex_wd         = wd_q;
  assign stall_timeout = to_q;

`ifdef ID_STALL_PERF_EN
  logic [31:0] pstall_q, pissue_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstall_q <= '0;
      pissue_q <= '0;
    end else if (perf_clr) begin
      pstall_q <= '0;
      pissue_q <= '0;
    end else begin
      if (dec_valid && !dec_ready) pstall_q <= pstall_q + 32'd1;
      if (xfer)                    pissue_q <= pissue_q + 32'd1;
    end
  end

  assign perf_stall_cnt = pstall_q;
  assign perf_issue_cnt = pissue_q;
`endif

endmodule
